// File: rtl/pmp_check_arbiter.sv
// ---------------------------------------------------------------------------
// pmp_check_arbiter
//
// Shares one PMP check unit between two requesters:
//   m0 = instruction fetch, m1 = load/store.
// A requester's grant is issued combinationally in IDLE. The winner's
// address, access type and current privilege are latched on that edge and
// presented to the checker in CHECK. A single allow/deny response strobe
// goes back to the winner in RESP. A checker that does not acknowledge
// within TIMEOUT cycles produces a forced deny with err set. New grants are
// held off while the PMP CSRs are being rewritten (cfg_busy_i).
//
// Configuration macro:
//   PMP_ARB_RR_EN  defined   -> round-robin arbitration between m0 and m1
//                  undefined -> m1 has fixed priority, and a starve counter
//                               lets m0 win after STARVE_LIMIT lost
//                               arbitrations
//
// Parameters:
//   ADDR_W        address width of requests and of the checker interface
//   TIMEOUT       maximum CHECK cycles before a forced deny (>= 2)
//   STARVE_LIMIT  lost arbitrations before m0 is forced to win (>= 1)
//
// Ports:
//   clk, rst                   clock; asynchronous active-low reset
//   mX_req_i/addr_i/acc_i      request, address, access type (X = 0, 1)
//   mX_gnt_o                   request accepted this cycle (IDLE only)
//   mX_rsp_valid_o             one-cycle response strobe
//   mX_allow_o, mX_err_o       verdict and timeout flag, 0 unless rsp_valid
//   priv_i                     privilege, sampled on grant
//   cfg_busy_i                 PMP CSR update in progress, blocks grants
//   chk_req_o                  check request to the PMP unit
//   chk_addr_o/acc_o/priv_o    latched request attributes
//   chk_ack_i, chk_allow_i     checker done and its verdict
//   busy_o                     arbiter is not idle
// ---------------------------------------------------------------------------
module pmp_check_arbiter #(
    parameter int ADDR_W       = 32,
    parameter int TIMEOUT      = 16,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              m0_req_i,
    input  logic [ADDR_W-1:0] m0_addr_i,
    input  logic [1:0]        m0_acc_i,
    output logic              m0_gnt_o,
    output logic              m0_rsp_valid_o,
    output logic              m0_allow_o,
    output logic              m0_err_o,

    input  logic              m1_req_i,
    input  logic [ADDR_W-1:0] m1_addr_i,
    input  logic [1:0]        m1_acc_i,
    output logic              m1_gnt_o,
    output logic              m1_rsp_valid_o,
    output logic              m1_allow_o,
    output logic              m1_err_o,

    input  logic [1:0]        priv_i,
    input  logic              cfg_busy_i,

    output logic              chk_req_o,
    output logic [ADDR_W-1:0] chk_addr_o,
    output logic [1:0]        chk_acc_o,
    output logic [1:0]        chk_priv_o,
    input  logic              chk_ack_i,
    input  logic              chk_allow_i,

    output logic              busy_o
);

    localparam int TMR_W = $clog2(TIMEOUT + 1);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CHECK = 2'd1,
        RESP  = 2'd2
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [TMR_W-1:0]  timer;
    logic              owner_m1;     // winner of the in-flight request
    logic              allow_q;
    logic              err_q;

    logic              pick_m1;      // arbitration result, valid in IDLE
    logic              grant_fire;   // a grant is issued this cycle
    logic              ack_hit;
    logic              timeout_hit;

    // -----------------------------------------------------------------------
    // Arbitration
    // -----------------------------------------------------------------------
`ifdef PMP_ARB_RR_EN
    // Reset value 1 means "m1 was granted last", so m0 wins first.
    logic last_m1;

    always_comb begin
        if (m0_req_i && m1_req_i) begin
            pick_m1 = !last_m1;
        end else begin
            pick_m1 = m1_req_i;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_m1 <= 1'b1;
        end else if (grant_fire) begin
            last_m1 <= pick_m1;
        end
    end
`else
    localparam int STV_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [STV_W-1:0] STARVE_MAX = STV_W'(STARVE_LIMIT);

    logic [STV_W-1:0] starve;

    // Counter saturates at the limit; it only matters that it reaches it.
    function automatic logic [STV_W-1:0] sat_inc(input logic [STV_W-1:0] v);
        return (v == STARVE_MAX) ? v : v + STV_W'(1);
    endfunction

    always_comb begin
        if (m0_req_i && m1_req_i) begin
            pick_m1 = (starve != STARVE_MAX);
        end else begin
            pick_m1 = m1_req_i;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            starve <= '0;
        end else if (grant_fire) begin
            if (!pick_m1) begin
                starve <= '0;
            end else if (m0_req_i) begin
                starve <= sat_inc(starve);
            end
        end
    end
`endif

    // -----------------------------------------------------------------------
    // FSM state register
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // -----------------------------------------------------------------------
    // FSM next state and outputs
    // -----------------------------------------------------------------------
    always_comb begin
        state_nxt      = state;
        grant_fire     = 1'b0;
        ack_hit        = 1'b0;
        timeout_hit    = 1'b0;
        m0_gnt_o       = 1'b0;
        m1_gnt_o       = 1'b0;
        m0_rsp_valid_o = 1'b0;
        m0_allow_o     = 1'b0;
        m0_err_o       = 1'b0;
        m1_rsp_valid_o = 1'b0;
        m1_allow_o     = 1'b0;
        m1_err_o       = 1'b0;
        chk_req_o      = 1'b0;
        busy_o         = (state != IDLE);

        case (state)
            IDLE: begin
                // Grants are combinational, so they are masked by reset too:
                // every output must read 0 while rst is low.
                if (rst && !cfg_busy_i && (m0_req_i || m1_req_i)) begin
                    grant_fire = 1'b1;
                    m0_gnt_o   = !pick_m1;
                    m1_gnt_o   = pick_m1;
                    state_nxt  = CHECK;
                end
            end
            CHECK: begin
                chk_req_o = 1'b1;
                if (chk_ack_i) begin
                    ack_hit   = 1'b1;
                    state_nxt = RESP;
                end else if (timer == TMR_LAST) begin
                    timeout_hit = 1'b1;
                    state_nxt   = RESP;
                end
            end
            RESP: begin
                m0_rsp_valid_o = !owner_m1;
                m0_allow_o     = !owner_m1 && allow_q;
                m0_err_o       = !owner_m1 && err_q;
                m1_rsp_valid_o = owner_m1;
                m1_allow_o     = owner_m1 && allow_q;
                m1_err_o       = owner_m1 && err_q;
                state_nxt      = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // Request latch, timer and verdict
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            chk_addr_o <= '0;
            chk_acc_o  <= '0;
            chk_priv_o <= '0;
            owner_m1   <= 1'b0;
            timer      <= '0;
            allow_q    <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            if (grant_fire) begin
                chk_addr_o <= pick_m1 ? m1_addr_i : m0_addr_i;
                chk_acc_o  <= pick_m1 ? m1_acc_i : m0_acc_i;
                chk_priv_o <= priv_i;
                owner_m1   <= pick_m1;
                timer      <= '0;
            end
            if (ack_hit) begin
                allow_q <= chk_allow_i;
                err_q   <= 1'b0;
            end else if (timeout_hit) begin
                allow_q <= 1'b0;
                err_q   <= 1'b1;
            end else if (state == CHECK) begin
                timer <= timer + TMR_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_pmp_check_arbiter.sv
module tb_pmp_check_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        m0_req_i, m1_req_i;
    logic [31:0] m0_addr_i, m1_addr_i;
    logic [1:0]  m0_acc_i, m1_acc_i, priv_i;
    logic        m0_gnt_o, m0_rsp_valid_o, m0_allow_o, m0_err_o;
    logic        m1_gnt_o, m1_rsp_valid_o, m1_allow_o, m1_err_o;
    logic        cfg_busy_i, chk_req_o, chk_ack_i, chk_allow_i, busy_o;
    logic [31:0] chk_addr_o;
    logic [1:0]  chk_acc_o, chk_priv_o;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pmp_check_arbiter #(.ADDR_W(32), .TIMEOUT(16), .STARVE_LIMIT(4)) dut (
        .clk(clk), .rst(rst),
        .m0_req_i(m0_req_i), .m0_addr_i(m0_addr_i), .m0_acc_i(m0_acc_i),
        .m0_gnt_o(m0_gnt_o), .m0_rsp_valid_o(m0_rsp_valid_o),
        .m0_allow_o(m0_allow_o), .m0_err_o(m0_err_o),
        .m1_req_i(m1_req_i), .m1_addr_i(m1_addr_i), .m1_acc_i(m1_acc_i),
        .m1_gnt_o(m1_gnt_o), .m1_rsp_valid_o(m1_rsp_valid_o),
        .m1_allow_o(m1_allow_o), .m1_err_o(m1_err_o),
        .priv_i(priv_i), .cfg_busy_i(cfg_busy_i),
        .chk_req_o(chk_req_o), .chk_addr_o(chk_addr_o), .chk_acc_o(chk_acc_o),
        .chk_priv_o(chk_priv_o), .chk_ack_i(chk_ack_i), .chk_allow_i(chk_allow_i),
        .busy_o(busy_o)
    );

    typedef struct packed {
        logic        m0_req;
        logic [31:0] m0_addr;
        logic [1:0]  m0_acc;
        logic        m1_req;
        logic [31:0] m1_addr;
        logic [1:0]  m1_acc;
        logic [1:0]  priv;
        logic        cfg_busy;
        logic        chk_ack;
        logic        chk_allow;
    } vin_t;

    typedef struct packed {
        logic        m0_gnt;
        logic        m1_gnt;
        logic        chk_req;
        logic        m0_rv;
        logic        m0_allow;
        logic        m0_err;
        logic        m1_rv;
        logic        m1_allow;
        logic        m1_err;
        logic        busy;
        logic [31:0] chk_addr;
        logic [1:0]  chk_acc;
        logic [1:0]  chk_priv;
    } vout_t;

    typedef struct packed {
        vin_t  i;
        vout_t o;
    } vec_t;

    vec_t vecs [9];

    function automatic vout_t sample_out();
        vout_t s;
        s = '{m0_gnt_o, m1_gnt_o, chk_req_o, m0_rsp_valid_o, m0_allow_o, m0_err_o,
              m1_rsp_valid_o, m1_allow_o, m1_err_o, busy_o, chk_addr_o, chk_acc_o,
              chk_priv_o};
        return s;
    endfunction

    task automatic apply(input vin_t v);
        m0_req_i    = v.m0_req;
        m0_addr_i   = v.m0_addr;
        m0_acc_i    = v.m0_acc;
        m1_req_i    = v.m1_req;
        m1_addr_i   = v.m1_addr;
        m1_acc_i    = v.m1_acc;
        priv_i      = v.priv;
        cfg_busy_i  = v.cfg_busy;
        chk_ack_i   = v.chk_ack;
        chk_allow_i = v.chk_allow;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    localparam logic [31:0] A0 = 32'h0000_4000;
    localparam logic [31:0] A1 = 32'h0000_5000;

    initial begin
        vout_t exp_o;
        logic  exp_m1;
        int    n;
        bit    done;

        // Vectors: one clock cycle each, inputs driven after the edge,
        // outputs compared mid-cycle.
        //            m0req m0addr        acc   m1req m1addr        acc   priv  cfg  ack  alw
        vecs[0].i = '{1'b0, 32'h0,        2'd0, 1'b0, 32'h0,        2'd0, 2'd0, 1'b0,1'b0,1'b0};
        vecs[0].o = '{1'b0,1'b0,1'b0, 1'b0,1'b0,1'b0, 1'b0,1'b0,1'b0, 1'b0, 32'h0, 2'd0, 2'd0};
        // single fetch request: grant at N
        vecs[1].i = '{1'b1, 32'h8000_0000,2'd2, 1'b0, 32'h0,        2'd0, 2'd3, 1'b0,1'b0,1'b0};
        vecs[1].o = '{1'b1,1'b0,1'b0, 1'b0,1'b0,1'b0, 1'b0,1'b0,1'b0, 1'b0, 32'h0, 2'd0, 2'd0};
        // N+1: check presented, checker acks with allow
        vecs[2].i = '{1'b0, 32'h0,        2'd0, 1'b0, 32'h0,        2'd0, 2'd0, 1'b0,1'b1,1'b1};
        vecs[2].o = '{1'b0,1'b0,1'b1, 1'b0,1'b0,1'b0, 1'b0,1'b0,1'b0, 1'b1, 32'h8000_0000, 2'd2, 2'd3};
        // N+2: response to m0
        vecs[3].i = '{1'b0, 32'h0,        2'd0, 1'b0, 32'h0,        2'd0, 2'd0, 1'b0,1'b0,1'b0};
        vecs[3].o = '{1'b0,1'b0,1'b0, 1'b1,1'b1,1'b0, 1'b0,1'b0,1'b0, 1'b1, 32'h8000_0000, 2'd2, 2'd3};
        vecs[4].i = '{1'b0, 32'h0,        2'd0, 1'b0, 32'h0,        2'd0, 2'd0, 1'b0,1'b0,1'b0};
        vecs[4].o = '{1'b0,1'b0,1'b0, 1'b0,1'b0,1'b0, 1'b0,1'b0,1'b0, 1'b0, 32'h8000_0000, 2'd2, 2'd3};
        // deny path: m1 write to 0x1000
        vecs[5].i = '{1'b0, 32'h0,        2'd0, 1'b1, 32'h0000_1000,2'd1, 2'd1, 1'b0,1'b0,1'b0};
        vecs[5].o = '{1'b0,1'b1,1'b0, 1'b0,1'b0,1'b0, 1'b0,1'b0,1'b0, 1'b0, 32'h8000_0000, 2'd2, 2'd3};
        vecs[6].i = '{1'b0, 32'h0,        2'd0, 1'b0, 32'h0,        2'd0, 2'd0, 1'b0,1'b1,1'b0};
        vecs[6].o = '{1'b0,1'b0,1'b1, 1'b0,1'b0,1'b0, 1'b0,1'b0,1'b0, 1'b1, 32'h0000_1000, 2'd1, 2'd1};
        vecs[7].i = '{1'b0, 32'h0,        2'd0, 1'b0, 32'h0,        2'd0, 2'd0, 1'b0,1'b0,1'b0};
        vecs[7].o = '{1'b0,1'b0,1'b0, 1'b0,1'b0,1'b0, 1'b1,1'b0,1'b0, 1'b1, 32'h0000_1000, 2'd1, 2'd1};
        // stray ack in IDLE is ignored
        vecs[8].i = '{1'b0, 32'h0,        2'd0, 1'b0, 32'h0,        2'd0, 2'd0, 1'b0,1'b1,1'b1};
        vecs[8].o = '{1'b0,1'b0,1'b0, 1'b0,1'b0,1'b0, 1'b0,1'b0,1'b0, 1'b0, 32'h0000_1000, 2'd1, 2'd1};

        // Reset state, with a request pending to show the grant is masked
        apply(vecs[0].i);
        rst      = 1'b0;
        m0_req_i = 1'b1;
        next_cycle();
        next_cycle();
        @(negedge clk);
        check("reset_outputs", 64'(sample_out()), 64'(vout_t'('0)));
        m0_req_i = 1'b0;
        rst      = 1'b1;

        for (int i = 0; i < 9; i++) begin
            next_cycle();
            apply(vecs[i].i);
            @(negedge clk);
            check($sformatf("vec%0d", i), 64'(sample_out()), 64'(vecs[i].o));
        end

        // Contention: both masters request continuously, immediate ack
        apply(vecs[0].i);
        m0_addr_i = A0;
        m1_addr_i = A1;
        for (int k = 0; k < 10; k++) begin
`ifdef PMP_ARB_RR_EN
            exp_m1 = (k % 2) == 1;
`else
            exp_m1 = !(k == 4 || k == 9);
`endif
            next_cycle();
            m0_req_i  = 1'b1;
            m1_req_i  = 1'b1;
            chk_ack_i = 1'b0;
            @(negedge clk);
            check($sformatf("arb%0d_gnt", k), {m0_gnt_o, m1_gnt_o}, {!exp_m1, exp_m1});
            next_cycle();
            chk_ack_i   = 1'b1;
            chk_allow_i = 1'b1;
            @(negedge clk);
            check($sformatf("arb%0d_chk", k), {chk_req_o, m0_gnt_o, m1_gnt_o, chk_addr_o},
                  {1'b1, 1'b0, 1'b0, exp_m1 ? A1 : A0});
            next_cycle();
            chk_ack_i = 1'b0;
            @(negedge clk);
            check($sformatf("arb%0d_rsp", k), {m0_rsp_valid_o, m1_rsp_valid_o, m0_gnt_o, m1_gnt_o},
                  {!exp_m1, exp_m1, 1'b0, 1'b0});
        end
        apply(vecs[0].i);

        // Timeout: checker never acks
        next_cycle();
        m0_req_i  = 1'b1;
        m0_addr_i = A0;
        @(negedge clk);
        check("to_gnt", m0_gnt_o, 1'b1);
        next_cycle();
        m0_req_i = 1'b0;
        n    = 0;
        done = 1'b0;
        for (int c = 0; c < 40 && !done; c++) begin
            @(negedge clk);
            if (chk_req_o) begin
                n++;
                next_cycle();
            end else begin
                done = 1'b1;
            end
        end
        check("to_req_cycles", n, 16);
        check("to_rsp", {m0_rsp_valid_o, m0_allow_o, m0_err_o, m1_rsp_valid_o},
              {1'b1, 1'b0, 1'b1, 1'b0});

        // CSR update hold-off
        next_cycle();
        cfg_busy_i = 1'b1;
        m1_req_i   = 1'b1;
        m1_addr_i  = A1;
        n = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (m0_gnt_o || m1_gnt_o || busy_o) n++;
            next_cycle();
        end
        check("cfg_hold_no_gnt", n, 0);
        cfg_busy_i = 1'b0;
        @(negedge clk);
        check("cfg_release_gnt", {m0_gnt_o, m1_gnt_o}, 2'b01);
        next_cycle();
        m1_req_i    = 1'b0;
        cfg_busy_i  = 1'b1;
        chk_ack_i   = 1'b1;
        chk_allow_i = 1'b1;
        @(negedge clk);
        check("cfg_inflight_chk", {chk_req_o, chk_addr_o}, {1'b1, A1});
        next_cycle();
        chk_ack_i = 1'b0;
        m1_req_i  = 1'b1;
        @(negedge clk);
        check("cfg_inflight_rsp", {m1_rsp_valid_o, m1_allow_o, m1_err_o}, 3'b110);
        next_cycle();
        @(negedge clk);
        check("cfg_blocks_next", {m0_gnt_o, m1_gnt_o, busy_o}, 3'b000);
        next_cycle();
        apply(vecs[0].i);

        // Reset asserted mid-CHECK
        next_cycle();
        m1_req_i  = 1'b1;
        m1_addr_i = A1;
        @(negedge clk);
        check("rst_gnt", m1_gnt_o, 1'b1);
        next_cycle();
        @(negedge clk);
        check("rst_in_check", chk_req_o, 1'b1);
        #1;
        rst = 1'b0;
        #1;
        check("rst_immediate", 64'(sample_out()), 64'(vout_t'('0)));
        next_cycle();
        @(negedge clk);
        rst      = 1'b1;
        m1_req_i = 1'b0;
        n = 0;
        for (int c = 0; c < 3; c++) begin
            next_cycle();
            @(negedge clk);
            if (m0_rsp_valid_o || m1_rsp_valid_o || busy_o) n++;
        end
        check("rst_no_rsp", n, 0);
        next_cycle();
        m1_req_i = 1'b1;
        @(negedge clk);
        check("post_rst_gnt", m1_gnt_o, 1'b1);
        next_cycle();
        m1_req_i    = 1'b0;
        chk_ack_i   = 1'b1;
        chk_allow_i = 1'b1;
        @(negedge clk);
        check("post_rst_chk", {chk_req_o, chk_addr_o}, {1'b1, A1});
        next_cycle();
        chk_ack_i = 1'b0;
        @(negedge clk);
        check("post_rst_rsp", {m1_rsp_valid_o, m1_allow_o, m1_err_o, m0_rsp_valid_o}, 4'b1100);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
